tcp_rx_tab_req_mc: RTL

Multi-cell descriptor front end for the TCP receive path. It sits between the RX parser's packet-descriptor (PD) stream and the connection-table lookup. It reassembles each PDSZ-cell descriptor and extracts forward mode, channel and flow ID. It then issues a table read request, a table-info word and a delayed copy of the PD cells to three downstream FIFOs. Compared with the previous generation it adds:
- descriptor-atomic backpressure
- per-channel polling-FID remap with a programmable modulus
- a configurable table entry stride
- live statistics counters

---
 rtl/tcp_rx_tab_req_mc.sv | 137 +++++++++++++
 1 files changed

// File: rtl/tcp_rx_tab_req_mc.sv
`default_nettype none
// ============================================================================
// Module : tcp_rx_tab_req_mc
// Reassembles multi-cell PDs, remaps the polling flow and issues table reads.
// Rev    : 1.0  initial release
// ============================================================================
module tcp_rx_tab_req_mc #(
    parameter int PDWID        = 128,
    parameter int PDSZ         = 4,
    parameter int TAB_AWID     = 12,
    parameter int ENTRY_SHIFT  = 1,
    parameter int TAB_INFO_WID = 16,
    parameter int POLL_CHN     = 2,
    parameter int POLL_FID     = 9,
    parameter int POLL_MOD     = 65536,
    parameter int DBG_WID      = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_pd_vld,
    input  logic [PDWID-1:0]        in_pd_dat,
    output logic                    in_pd_rdy,
    output logic                    tab_rreq_fifo_wen,
    output logic [TAB_AWID-1:0]     tab_rreq_fifo_wdata,
    input  logic                    tab_rreq_fifo_nafull,
    output logic                    pd_fifo_wen,
    output logic [PDWID-1:0]        pd_fifo_wdata,
    input  logic                    pd_fifo_nafull,
    output logic                    tab_info_fifo_wen,
    output logic [TAB_INFO_WID-1:0] tab_info_fifo_wdata,
    input  logic                    tab_info_fifo_nafull,
    output logic [DBG_WID-1:0]      dbg_sig
);

    localparam int                  c_cnt_w     = (PDSZ > 2) ? $clog2(PDSZ) : 1;
    localparam int                  c_fid_w     = TAB_INFO_WID - 2;
    localparam logic [c_cnt_w-1:0]  c_last_cell = c_cnt_w'(PDSZ - 1);
    localparam logic [c_fid_w-1:0]  c_poll_fid  = c_fid_w'(POLL_FID);
    localparam logic [3:0]          c_poll_chn  = 4'(POLL_CHN);
    localparam logic [15:0]         c_poll_last = 16'(POLL_MOD - 1);

    logic [c_cnt_w-1:0]      cell_cnt_q, cell_cnt_d;
    logic [1:0]              fwd_q;
    logic [3:0]              chn_q;
    logic [15:0]             fid_q;
    logic [15:0]             poll_cnt_q;
    logic [15:0]             desc_cnt_q;
    logic [15:0]             req_cnt_q;

    logic                    pd_wen_q;
    logic [PDWID-1:0]        pd_wdata_q;
    logic                    info_wen_q;
    logic [TAB_INFO_WID-1:0] info_wdata_q;
    logic                    rreq_wen_q;
    logic [TAB_AWID-1:0]     rreq_wdata_q;

    logic                    w_accept;
    logic                    w_last;
    logic                    w_remap;
    logic                    w_is_tbd;
    logic [15:0]             w_eff_fid;
    logic [1:0]              w_tag;
    logic [TAB_AWID-1:0]     w_rreq_addr;

    // A descriptor in flight is never stalled; downstream headroom covers its tail.
    assign in_pd_rdy = (cell_cnt_q != '0) ||
                       (tab_rreq_fifo_nafull && pd_fifo_nafull && tab_info_fifo_nafull);
    assign w_accept  = in_pd_vld && in_pd_rdy;
    assign w_last    = w_accept && (cell_cnt_q == c_last_cell);

    always_comb begin
        cell_cnt_d  = cell_cnt_q;
        if (w_accept) begin
            cell_cnt_d = (cell_cnt_q == c_last_cell) ? '0 : cell_cnt_q + 1'b1;
        end
        w_remap     = (chn_q == c_poll_chn) && (fid_q[c_fid_w-1:0] == c_poll_fid);
        w_eff_fid   = w_remap ? poll_cnt_q : fid_q;
        w_is_tbd    = (fwd_q == 2'd0);
        w_tag       = w_is_tbd ? 2'b11 : 2'b01;
        w_rreq_addr = TAB_AWID'(32'(w_eff_fid) << ENTRY_SHIFT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cell_cnt_q   <= '0;
            fwd_q        <= '0;
            chn_q        <= '0;
            fid_q        <= '0;
            poll_cnt_q   <= '0;
            desc_cnt_q   <= '0;
            req_cnt_q    <= '0;
            pd_wen_q     <= 1'b0;
            pd_wdata_q   <= '0;
            info_wen_q   <= 1'b0;
            info_wdata_q <= '0;
            rreq_wen_q   <= 1'b0;
            rreq_wdata_q <= '0;
        end else begin
            cell_cnt_q <= cell_cnt_d;
            pd_wen_q   <= w_accept;
            info_wen_q <= w_last;
            rreq_wen_q <= w_last && w_is_tbd;

            if (w_accept) begin
                pd_wdata_q <= in_pd_dat;
            end

            if (w_accept && (cell_cnt_q == '0)) begin
                fwd_q <= in_pd_dat[PDWID-1 -: 2];
                chn_q <= in_pd_dat[PDWID-3 -: 4];
                fid_q <= in_pd_dat[15:0];
            end

            if (w_last) begin
                info_wdata_q <= {w_eff_fid[c_fid_w-1:0], w_tag};
                desc_cnt_q   <= desc_cnt_q + 16'd1;
                if (w_is_tbd) begin
                    rreq_wdata_q <= w_rreq_addr;
                    req_cnt_q    <= req_cnt_q + 16'd1;
                end
                if (w_remap) begin
                    poll_cnt_q <= (poll_cnt_q == c_poll_last) ? 16'd0 : poll_cnt_q + 16'd1;
                end
            end
        end
    end

    assign pd_fifo_wen         = pd_wen_q;
    assign pd_fifo_wdata       = pd_wdata_q;
    assign tab_info_fifo_wen   = info_wen_q;
    assign tab_info_fifo_wdata = info_wdata_q;
    assign tab_rreq_fifo_wen   = rreq_wen_q;
    assign tab_rreq_fifo_wdata = rreq_wdata_q;
    assign dbg_sig             = DBG_WID'({req_cnt_q, desc_cnt_q});

endmodule
`default_nettype wire
